// File: rtl/ppg_led_sequencer.sv
// ppg_led_sequencer: time-division LED controller for the PPG fingerclip front end.
//
// Each frame drives the red LED, then a dark gap, then the IR LED, then a second dark
// gap. Vppg is sampled once at the end of each LED-on window. The sampled value steps
// that channel's DC compensation so Vppg stays inside [WIN_LO, WIN_HI]. It also tracks
// a per-channel lock flag. The two LEDs are never on together, and every LED change
// passes through a dark gap.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   enable       in   start/continue sequencing (sampled in IDLE and at end of DARK2)
//   Vppg[7:0]    in   front-end PPG voltage code
//   LED_RED      out  red LED drive (registered)
//   LED_IR       out  IR LED drive (registered)
//   DC_Comp[6:0] out  DC compensation for the active/next channel
//   PGA_Gain[3:0] out PGA gain for the active/next channel
//   sample_data  out  last captured Vppg
//   sample_ch    out  channel of last sample (0 = red, 1 = IR)
//   sample_valid out  one-cycle pulse per captured sample
//   red_locked   out  red DC loop in window
//   ir_locked    out  IR DC loop in window
//
// Optional feature macro: PPG_PGA_AUTO_EN. When it is defined, each sample also adjusts
// that channel's PGA gain. A railed sample (0 or 255) lowers the gain. A locked sample
// near the window centre raises it. When it is undefined, both gains stay at PGA_INIT.

module ppg_led_sequencer #(
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned DARK_CYC   = 8,
    parameter int unsigned WIN_LO     = 64,
    parameter int unsigned WIN_HI     = 192,
    parameter int unsigned DC_INIT    = 64,
    parameter int unsigned PGA_INIT   = 4,
    parameter int unsigned LOCK_CNT   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] Vppg,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [6:0] DC_Comp,
    output logic [3:0] PGA_Gain,
    output logic [7:0] sample_data,
    output logic       sample_ch,
    output logic       sample_valid,
    output logic       red_locked,
    output logic       ir_locked
);

    localparam int unsigned CNT_MAX = (SETTLE_CYC > DARK_CYC) ? SETTLE_CYC : DARK_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned LW      = $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] DARK_LAST   = CW'(DARK_CYC - 1);
    localparam logic [LW-1:0] LOCK_FULL   = LW'(LOCK_CNT);
    localparam logic [7:0]    WIN_LO_V    = 8'(WIN_LO);
    localparam logic [7:0]    WIN_HI_V    = 8'(WIN_HI);
    localparam logic [6:0]    DC_RST      = 7'(DC_INIT);
    localparam logic [6:0]    DC_MAX      = 7'd127;
    localparam logic [3:0]    PGA_RST     = 4'(PGA_INIT);

    typedef enum logic [2:0] {
        StIdle,
        StRedSettle,
        StRedSamp,
        StDark1,
        StIrSettle,
        StIrSamp,
        StDark2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          led_red_q, led_ir_q;
    logic [6:0]    dc_comp_q;
    logic [3:0]    pga_gain_q;
    logic [7:0]    sample_data_q;
    logic          sample_ch_q;
    logic          sample_valid_q;

    logic [6:0]    dc_red_q, dc_ir_q;
    logic [3:0]    pga_red_q, pga_ir_q;
    logic [LW-1:0] lcnt_red_q, lcnt_ir_q;
    logic          red_lock_q, ir_lock_q;

    logic          samp_red, samp_ir, samp_any;
    logic [6:0]    cur_dc, upd_dc;
    logic [3:0]    cur_pga, upd_pga;
    logic [LW-1:0] cur_lcnt, upd_lcnt;
    logic          upd_lock;
    logic          above, below, in_win;

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StRedSettle;
                    cnt_d   = '0;
                end
            end
            StRedSettle: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = StRedSamp;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRedSamp: begin
                state_d = StDark1;
                cnt_d   = '0;
            end
            StDark1: begin
                if (cnt_q == DARK_LAST) begin
                    state_d = StIrSettle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIrSettle: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = StIrSamp;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIrSamp: begin
                state_d = StDark2;
                cnt_d   = '0;
            end
            StDark2: begin
                // enable is only looked at here, so a mid-frame drop finishes the frame.
                if (cnt_q == DARK_LAST) begin
                    state_d = enable ? StRedSettle : StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign samp_red = (state_q == StRedSamp);
    assign samp_ir  = (state_q == StIrSamp);
    assign samp_any = samp_red | samp_ir;

    // ------------------------------------------- per-sample loop update (shared)
`ifdef PPG_PGA_AUTO_EN
    localparam logic [7:0] PGA_UP_LO = 8'(WIN_LO + 32);
    localparam logic [7:0] PGA_UP_HI = 8'(WIN_HI - 32);
    logic cur_lock;
    assign cur_lock = samp_ir ? ir_lock_q : red_lock_q;
`endif

    always_comb begin
        cur_dc   = samp_ir ? dc_ir_q : dc_red_q;
        cur_pga  = samp_ir ? pga_ir_q : pga_red_q;
        cur_lcnt = samp_ir ? lcnt_ir_q : lcnt_red_q;
        above    = (Vppg > WIN_HI_V);
        below    = (Vppg < WIN_LO_V);
        in_win   = ~above & ~below;

        upd_dc = cur_dc;
        if (above && cur_dc != DC_MAX) begin
            upd_dc = cur_dc + 1'b1;
        end else if (below && cur_dc != '0) begin
            upd_dc = cur_dc - 1'b1;
        end

        if (!in_win) begin
            upd_lcnt = '0;
        end else if (cur_lcnt == LOCK_FULL) begin
            upd_lcnt = cur_lcnt;
        end else begin
            upd_lcnt = cur_lcnt + 1'b1;
        end
        upd_lock = in_win && (upd_lcnt == LOCK_FULL);

        upd_pga = cur_pga;
`ifdef PPG_PGA_AUTO_EN
        // Gain decisions use the lock state from before this sample.
        if (Vppg == 8'd255 || Vppg == 8'd0) begin
            if (cur_pga != 4'd0) begin
                upd_pga = cur_pga - 1'b1;
            end
            upd_lcnt = '0;
            upd_lock = 1'b0;
        end else if (Vppg >= PGA_UP_LO && Vppg <= PGA_UP_HI && cur_lock &&
                     cur_pga != 4'd15) begin
            upd_pga = cur_pga + 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------ registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            led_red_q      <= 1'b0;
            led_ir_q       <= 1'b0;
            dc_comp_q      <= DC_RST;
            pga_gain_q     <= PGA_RST;
            sample_data_q  <= '0;
            sample_ch_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            dc_red_q       <= DC_RST;
            dc_ir_q        <= DC_RST;
            pga_red_q      <= PGA_RST;
            pga_ir_q       <= PGA_RST;
            lcnt_red_q     <= '0;
            lcnt_ir_q      <= '0;
            red_lock_q     <= 1'b0;
            ir_lock_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            // LEDs decoded from the next state, so they line up with state_q exactly.
            led_red_q      <= (state_d == StRedSettle) || (state_d == StRedSamp);
            led_ir_q       <= (state_d == StIrSettle) || (state_d == StIrSamp);
            sample_valid_q <= samp_any;
            if (samp_any) begin
                sample_data_q <= Vppg;
                sample_ch_q   <= samp_ir;
            end
            if (samp_red) begin
                dc_red_q   <= upd_dc;
                pga_red_q  <= upd_pga;
                lcnt_red_q <= upd_lcnt;
                red_lock_q <= upd_lock;
            end
            if (samp_ir) begin
                dc_ir_q   <= upd_dc;
                pga_ir_q  <= upd_pga;
                lcnt_ir_q <= upd_lcnt;
                ir_lock_q <= upd_lock;
            end
            // Preload on entry to the dark gap: the outputs show the other channel's
            // settings before its LED turns on.
            if (samp_red) begin
                dc_comp_q  <= dc_ir_q;
                pga_gain_q <= pga_ir_q;
            end else if (samp_ir) begin
                dc_comp_q  <= dc_red_q;
                pga_gain_q <= pga_red_q;
            end
        end
    end

    assign LED_RED      = led_red_q;
    assign LED_IR       = led_ir_q;
    assign DC_Comp      = dc_comp_q;
    assign PGA_Gain     = pga_gain_q;
    assign sample_data  = sample_data_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = sample_valid_q;
    assign red_locked   = red_lock_q;
    assign ir_locked    = ir_lock_q;

endmodule
